btn_event_decoder: RTL and testbench
====================================

// Module: btn_event_decoder
// PURPOSE
//   Sits directly downstream of the button debouncer and consumes its clean level.
//   Converts the level into one-cycle event pulses: press, short press, long press,
//   auto-repeat and release.
//   Feeds the control FSMs, such as mode select and counter set/adjust, so that they
//   never see raw levels.
// PARAMETERS
//   CNT_W          26          hold-counter width in bits
//   LONG_CYCLES    25_000_000  sampled-high cycles before long_press fires (0.5 s @ 50 MHz); 1..2^CNT_W-1
//   REPEAT_CYCLES  5_000_000   period of repeat_pulse while long-held (0.1 s @ 50 MHz); 1..2^CNT_W-1
//   REPEAT_EN      1           1: auto-repeat enabled; 0: repeat_pulse tied 0
// PORTS
//   clk          in   1  system clock; all logic on posedge
//   rst          in   1  synchronous, active-high reset
//   btn          in   1  debounced button level (from debouncer btn_out)
//   press_pulse  out  1  1-cycle pulse on a 0->1 transition of btn
//   short_press  out  1  1-cycle pulse on release before the long threshold
//   long_press   out  1  1-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse out  1  1-cycle pulse every REPEAT_CYCLES while long-held
//   release_pulse out 1  1-cycle pulse on any 1->0 transition seen in PRESSED/HELD
//   held         out  1  level: 1 while state != IDLE
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-high.
//   - Registered outputs:
//     - All outputs are registered; a condition sampled at edge k appears in the
//       cycle after edge k.
//     - Every pulse output is high for exactly one cycle.
//   - Reset:
//     - When rst=1 at an edge: state=IDLE, cnt=0, all outputs=0, and btn_q=1.
//     - rst has priority over all other logic.
//     - Because btn_q resets to 1, a button held through reset creates no press.
//       It must go low, then high again.
//   - btn_q <= btn on every non-reset edge. It is used for edge detection only.
//   - States: IDLE, PRESSED, HELD. Counter cnt[CNT_W-1:0].
//   - IDLE:
//     - btn=1 and btn_q=0 -> press_pulse=1, go to PRESSED, cnt=0.
//     - Otherwise stay in IDLE.
//   - PRESSED:
//     - btn=0 -> short_press=1, release_pulse=1, go to IDLE, cnt=0.
//     - Otherwise, if cnt==LONG_CYCLES-1 -> long_press=1, go to HELD, cnt=0.
//     - Otherwise cnt<=cnt+1.
//     - Net effect: long_press is registered at edge k+LONG_CYCLES, where k is the
//       press edge.
//     - If btn is low at that edge, it is a short press. Release wins over long.
//   - HELD:
//     - btn=0 -> release_pulse=1, go to IDLE, cnt=0. No short_press.
//     - Otherwise, if REPEAT_EN and cnt==REPEAT_CYCLES-1 -> repeat_pulse=1, cnt=0.
//     - Otherwise cnt<=cnt+1. When REPEAT_EN=0, cnt saturates at REPEAT_CYCLES-1.
//   - held=1 in the cycle after any edge that leaves the FSM in PRESSED or HELD.
//   - Counter rules:
//     - cnt never wraps. Comparisons are equality against parameter-1, truncated to CNT_W.
//     - LONG_CYCLES=1 gives long_press at edge k+1.
//   - Mutual exclusion:
//     - press_pulse and release_pulse are never high in the same cycle.
//     - A 1-cycle btn glitch (0,1,0) gives press_pulse then short_press+release_pulse
//       on consecutive cycles.
//   - Reset mid-hold: all pulses are suppressed and the state is IDLE.
//     Note: no release_pulse is emitted for the interrupted press.
// TESTING (bench params: LONG_CYCLES=8, REPEAT_CYCLES=3, CNT_W=4, REPEAT_EN=1)
//   1. rst 2 cycles with btn=0, then btn high 3 edges, then low -> press_pulse once;
//      short_press+release_pulse once, 3 cycles later; held high 3 cycles; no long_press.
//   2. btn high 8 edges -> long_press exactly at edge k+8; held high throughout;
//      short_press never fires.
//   3. btn high 17 edges -> long_press @k+8, repeat_pulse @k+11,k+14,k+17;
//      on release, release_pulse only.
//   4. btn=1 across rst deassert, held 20 cycles -> no outputs.
//      Then btn 0 then 1 -> press_pulse fires.
//   5. Press, then rst at edge k+5 -> all outputs 0 next cycle; state IDLE; no release_pulse.
//   6. btn low exactly at edge k+8 (7 high samples after k) -> short_press, no long_press.
//      Repeat the run with REPEAT_EN=0 and a 20-edge hold: zero repeat_pulse.

Source files
------------

// File: rtl/btn_event_decoder.sv
// Turns the debounced button level into one-cycle press/short/long/repeat/release
// events plus a held level; every output is registered.
module btn_event_decoder #(
   parameter int CNT_W         = 26,
   parameter int LONG_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 5_000_000,
   parameter int REPEAT_EN     = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press_pulse,
   output logic short_press,
   output logic long_press,
   output logic repeat_pulse,
   output logic release_pulse,
   output logic held
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   state_t           r_state;
   state_t           w_stateNext;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cntNext;
   logic             r_btnQ;
   logic             w_press;
   logic             w_short;
   logic             w_long;
   logic             w_repeat;
   logic             w_release;

   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_press     = 1'b0;
      w_short     = 1'b0;
      w_long      = 1'b0;
      w_repeat    = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         IDLE: begin
            if (btn && !r_btnQ) begin
               w_press     = 1'b1;
               w_stateNext = PRESSED;
               w_cntNext   = '0;
            end
         end
         PRESSED: begin
            // Release is checked first so it beats a coincident long threshold.
            if (!btn) begin
               w_short     = 1'b1;
               w_release   = 1'b1;
               w_stateNext = IDLE;
               w_cntNext   = '0;
            end else if (r_cnt == LONG_LAST) begin
               w_long      = 1'b1;
               w_stateNext = HELD;
               w_cntNext   = '0;
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end
         HELD: begin
            // With repeat disabled the counter parks at the repeat limit.
            if (!btn) begin
               w_release   = 1'b1;
               w_stateNext = IDLE;
               w_cntNext   = '0;
            end else if (r_cnt == REPEAT_LAST) begin
               if (REPEAT_EN != 0) begin
                  w_repeat  = 1'b1;
                  w_cntNext = '0;
               end
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
         end
      endcase
   end

   // btn_q resets high so a button held through reset never counts as a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_btnQ        <= 1'b1;
         press_pulse   <= 1'b0;
         short_press   <= 1'b0;
         long_press    <= 1'b0;
         repeat_pulse  <= 1'b0;
         release_pulse <= 1'b0;
         held          <= 1'b0;
      end else begin
         r_state       <= w_stateNext;
         r_cnt         <= w_cntNext;
         r_btnQ        <= btn;
         press_pulse   <= w_press;
         short_press   <= w_short;
         long_press    <= w_long;
         repeat_pulse  <= w_repeat;
         release_pulse <= w_release;
         held          <= (w_stateNext != IDLE);
      end
   end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed vector bench for btn_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=3, CNT_W=4;
// a second instance with auto-repeat disabled shares the same stimulus.
module tb_btn_event_decoder;

   // Expected bit order: {press, short, long, repeat, release, held}
   typedef struct {
      logic       rst;
      logic       btn;
      logic [5:0] exp;
   } vec_t;

   localparam logic [5:0] NONE   = 6'b000000;
   localparam logic [5:0] PRESS  = 6'b100001;
   localparam logic [5:0] HOLD   = 6'b000001;
   localparam logic [5:0] SHORT  = 6'b010010;
   localparam logic [5:0] LONG   = 6'b001001;
   localparam logic [5:0] REPT   = 6'b000101;
   localparam logic [5:0] REL    = 6'b000010;
   localparam logic [5:0] NO_REP = 6'b111011;

   logic clk;
   logic rst;
   logic btn;
   logic press0, short0, long0, rep0, rel0, held0;
   logic press1, short1, long1, rep1, rel1, held1;
   logic [5:0] out0;
   logic [5:0] out1;

   int   checks;
   int   errors;
   vec_t vecs[$];

   assign out0 = {press0, short0, long0, rep0, rel0, held0};
   assign out1 = {press1, short1, long1, rep1, rel1, held1};

   btn_event_decoder #(
      .CNT_W(4), .LONG_CYCLES(8), .REPEAT_CYCLES(3), .REPEAT_EN(1)
   ) dutRep (
      .clk(clk), .rst(rst), .btn(btn),
      .press_pulse(press0), .short_press(short0), .long_press(long0),
      .repeat_pulse(rep0), .release_pulse(rel0), .held(held0)
   );

   btn_event_decoder #(
      .CNT_W(4), .LONG_CYCLES(8), .REPEAT_CYCLES(3), .REPEAT_EN(0)
   ) dutNoRep (
      .clk(clk), .rst(rst), .btn(btn),
      .press_pulse(press1), .short_press(short1), .long_press(long1),
      .repeat_pulse(rep1), .release_pulse(rel1), .held(held1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic addVec(input logic r, input logic b, input logic [5:0] e, input int n);
      vec_t v;
      v.rst = r;
      v.btn = b;
      v.exp = e;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   // Inputs change 1 time unit after an edge, so outputs read here reflect that edge.
   task automatic applyStimulus(input logic r, input logic b);
      rst = r;
      btn = b;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [5:0] actual, input logic [5:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s got %b expected %b", name, actual, expected);
      end
   endtask

   task automatic checkCount(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
      end
   endtask

   initial begin
      int repCnt0, repCnt1, longCnt0, longCnt1, heldCnt1;
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      btn    = 1'b0;

      // Reset, then a short press of 3 high edges
      addVec(1, 0, NONE, 2);
      addVec(0, 0, NONE, 1);
      addVec(0, 1, PRESS, 1);
      addVec(0, 1, HOLD, 2);
      addVec(0, 0, SHORT, 1);
      addVec(0, 0, NONE, 1);
      // Long hold of 18 high edges: long at k+8, repeats at k+11/14/17
      addVec(0, 1, PRESS, 1);
      addVec(0, 1, HOLD, 7);
      addVec(0, 1, LONG, 1);
      for (int r = 0; r < 3; r++) begin
         addVec(0, 1, HOLD, 2);
         addVec(0, 1, REPT, 1);
      end
      addVec(0, 0, REL, 1);
      addVec(0, 0, NONE, 1);
      // Release exactly on the long-threshold edge is a short press
      addVec(0, 1, PRESS, 1);
      addVec(0, 1, HOLD, 7);
      addVec(0, 0, SHORT, 1);
      addVec(0, 0, NONE, 1);
      // Single-cycle glitch
      addVec(0, 1, PRESS, 1);
      addVec(0, 0, SHORT, 1);
      addVec(0, 0, NONE, 1);
      // Button held through reset produces nothing until it drops and rises
      addVec(1, 1, NONE, 2);
      addVec(0, 1, NONE, 20);
      addVec(0, 0, NONE, 1);
      addVec(0, 1, PRESS, 1);
      addVec(0, 0, SHORT, 1);
      addVec(0, 0, NONE, 1);
      // Reset in the middle of a press: no release pulse afterwards
      addVec(0, 1, PRESS, 1);
      addVec(0, 1, HOLD, 4);
      addVec(1, 1, NONE, 1);
      addVec(0, 1, NONE, 3);
      addVec(0, 0, NONE, 1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].btn);
         checkOutput($sformatf("vec%0d rep", i), out0, vecs[i].exp);
         checkOutput($sformatf("vec%0d norep", i), out1, vecs[i].exp & NO_REP);
      end

      // 21-edge hold counting events on both instances
      repCnt0  = 0;
      repCnt1  = 0;
      longCnt0 = 0;
      longCnt1 = 0;
      heldCnt1 = 0;
      for (int e = 0; e <= 20; e++) begin
         applyStimulus(0, 1);
         repCnt0  += int'(rep0);
         repCnt1  += int'(rep1);
         longCnt0 += int'(long0);
         longCnt1 += int'(long1);
         heldCnt1 += int'(held1);
      end
      checkCount("longhold repeats rep", repCnt0, 4);
      checkCount("longhold repeats norep", repCnt1, 0);
      checkCount("longhold long rep", longCnt0, 1);
      checkCount("longhold long norep", longCnt1, 1);
      checkCount("longhold held norep", heldCnt1, 21);
      applyStimulus(0, 0);
      checkOutput("longhold release rep", out0, REL);
      checkOutput("longhold release norep", out1, REL);
      applyStimulus(0, 0);
      checkOutput("longhold idle rep", out0, NONE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
